// File: rtl/rx_seq_ctrl.sv
// rx_seq_ctrl: sequences ROM reads, multiplier clear/enable and result capture for one accumulation frame
module rx_seq_ctrl #(
    parameter int FRAME_LEN = 4096,
    parameter int ROM_DEPTH = 8,
    parameter int ADDR_W    = 3,
    parameter int ROM_LAT   = 1,
    parameter int DRAIN_CYC = 3
) (
    input  logic              I_sys_clk,
    input  logic              I_sys_rst,
    input  logic              I_start,
    input  logic              I_abort,
    input  logic              I_continuous,
    output logic              O_rom_ena,
    output logic [ADDR_W-1:0] O_rom_addr,
    output logic              O_mult_clr,
    output logic              O_mult_ena,
    output logic              O_capture,
    output logic              O_busy,
    output logic              O_done
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int DRN_W = $clog2(DRAIN_CYC + 1);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, CAPTURE, DONE} state_t;
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DRN_W-1:0]   drn;
    logic [ROM_LAT-1:0] pipe;
    // multiplier enable tracks ROM data valid, ROM_LAT cycles behind the read enable
    assign O_mult_ena = pipe[ROM_LAT-1];
    always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
        if (I_sys_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            drn        <= '0;
            pipe       <= '0;
            O_rom_ena  <= 1'b0;
            O_rom_addr <= '0;
            O_mult_clr <= 1'b0;
            O_capture  <= 1'b0;
            O_busy     <= 1'b0;
            O_done     <= 1'b0;
        end else begin
            pipe       <= (pipe << 1) | ROM_LAT'(O_rom_ena);
            O_mult_clr <= 1'b0;
            O_capture  <= 1'b0;
            O_done     <= 1'b0;
            if (I_abort && state != IDLE) begin
                state      <= IDLE;
                cnt        <= '0;
                drn        <= '0;
                pipe       <= '0;
                O_rom_ena  <= 1'b0;
                O_rom_addr <= '0;
                O_busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (I_start && !I_abort) begin
                        state      <= CLEAR;
                        O_mult_clr <= 1'b1;
                        O_busy     <= 1'b1;
                        cnt        <= '0;
                        O_rom_addr <= '0;
                    end
                    CLEAR: begin
                        state      <= RUN;
                        O_rom_ena  <= 1'b1;
                        O_rom_addr <= '0;
                        cnt        <= '0;
                    end
                    RUN: if (cnt == CNT_W'(FRAME_LEN - 1)) begin
                        state      <= DRAIN;
                        O_rom_ena  <= 1'b0;
                        O_rom_addr <= '0;
                        cnt        <= '0;
                        drn        <= '0;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        O_rom_addr <= (O_rom_addr == ADDR_W'(ROM_DEPTH - 1)) ? '0 : O_rom_addr + 1'b1;
                    end
                    DRAIN: if (drn == DRN_W'(DRAIN_CYC - 1)) begin
                        state     <= CAPTURE;
                        O_capture <= 1'b1;
                        drn       <= '0;
                    end else begin
                        drn <= drn + 1'b1;
                    end
                    CAPTURE: begin
                        state  <= DONE;
                        O_done <= 1'b1;
                    end
                    DONE: if (I_continuous) begin
                        state      <= CLEAR;
                        O_mult_clr <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        O_busy <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        O_busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rx_seq_ctrl.sv
// tb_rx_seq_ctrl: two configurations (8/8 and 12/5) checked each cycle against a frame-position model
module tb_rx_seq_ctrl;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, cont = 1'b0;
    logic ena0, clr0, mena0, cap0, busy0, done0;
    logic ena1, clr1, mena1, cap1, busy1, done1;
    logic [2:0] addr0, addr1;
    int errors = 0, checks = 0, t0 = 0, t1 = 0;
    logic c = 1'b0;

    always #5 clk = ~clk;

    rx_seq_ctrl #(.FRAME_LEN(8), .ROM_DEPTH(8), .ADDR_W(3), .ROM_LAT(1), .DRAIN_CYC(3)) dut0 (
        .I_sys_clk(clk), .I_sys_rst(rst), .I_start(start), .I_abort(abort), .I_continuous(cont),
        .O_rom_ena(ena0), .O_rom_addr(addr0), .O_mult_clr(clr0), .O_mult_ena(mena0),
        .O_capture(cap0), .O_busy(busy0), .O_done(done0));

    rx_seq_ctrl #(.FRAME_LEN(12), .ROM_DEPTH(5), .ADDR_W(3), .ROM_LAT(1), .DRAIN_CYC(3)) dut1 (
        .I_sys_clk(clk), .I_sys_rst(rst), .I_start(start), .I_abort(abort), .I_continuous(cont),
        .O_rom_ena(ena1), .O_rom_addr(addr1), .O_mult_clr(clr1), .O_mult_ena(mena1),
        .O_capture(cap1), .O_busy(busy1), .O_done(done1));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // t = cycles since the start edge (0 = idle); frame spans t=1..fl+6 with DRAIN_CYC=3
    function automatic int nxt(int t, int fl, logic s, logic a, logic cn);
        if (t == 0) return (s && !a) ? 1 : 0;
        if (a) return 0;
        if (t == fl + 6) return cn ? 1 : 0;
        return t + 1;
    endfunction

    // packed {busy, done, capture, mult_ena, mult_clr, rom_ena, addr[2:0]}
    function automatic int expv(int t, int fl, int rd);
        logic e;
        logic [2:0] a;
        e = (t >= 2) && (t <= fl + 1);
        a = e ? 3'((t - 2) % rd) : 3'd0;
        return int'({(t >= 1) && (t <= fl + 6), t == fl + 6, t == fl + 5, (t >= 3) && (t <= fl + 2), t == 1, e, a});
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t0 = 0;
            t1 = 0;
        end else begin
            t0 = nxt(t0, 8, start, abort, cont);
            t1 = nxt(t1, 12, start, abort, cont);
        end
    end

    always @(negedge clk) begin
        chk("cfg8", int'({busy0, done0, cap0, mena0, clr0, ena0, addr0}), expv(t0, 8, 8));
        chk("cfg12", int'({busy1, done1, cap1, mena1, clr1, ena1, addr1}), expv(t1, 12, 5));
    end

    task automatic step(input logic s, input logic a, input logic cn);
        @(negedge clk);
        start = s;
        abort = a;
        cont  = cn;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0);
        repeat (20) step(0, 0, 0);
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        repeat (7) step(0, 0, 0);
        step(1, 0, 0);
        repeat (20) step(0, 0, 0);
        step(1, 0, 0);
        repeat (5) step(0, 0, 0);
        step(0, 1, 0);
        repeat (20) step(0, 0, 0);
        step(1, 0, 1);
        repeat (40) step(0, 0, 1);
        repeat (20) step(0, 0, 0);
        step(1, 1, 0);
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        repeat (11) step(0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async8", int'({busy0, done0, cap0, mena0, clr0, ena0, addr0}), expv(t0, 8, 8));
        chk("async12", int'({busy1, done1, cap1, mena1, clr1, ena1, addr1}), expv(t1, 12, 5));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (700) begin
            if ($urandom_range(0, 19) == 0) c = ~c;
            step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, c);
        end
        repeat (25) step(0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rx_seq_ctrl.md
RX_SEQ_CTRL -- requirements
Module: rx_seq_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 4096: number of ROM samples per accumulation frame; legal range 2..65535.
REQ-002 Parameter ROM_DEPTH, default 8: number of ROM words; the address wraps after ROM_DEPTH-1.
REQ-003 Parameter ADDR_W, default 3: ROM address width; ROM_DEPTH SHALL be <= 2^ADDR_W.
REQ-004 Parameter ROM_LAT, default 1: cycles from O_rom_ena to ROM data valid; range 1..4.
REQ-005 Parameter DRAIN_CYC, default 3: cycles between the last ROM read and the capture; DRAIN_CYC SHALL be >= ROM_LAT+1.
REQ-006 I_sys_clk  in  1  sole clock; all flops on the rising edge.
REQ-007 I_sys_rst  in  1  asynchronous reset, active-high.
REQ-008 I_start  in  1  single-cycle request to run one frame.
REQ-009 I_abort  in  1  terminates any frame in progress.
REQ-010 I_continuous  in  1  when high, a new frame starts automatically after DONE.
REQ-011 O_rom_ena  out  1  ROM read enable.
REQ-012 O_rom_addr  out  ADDR_W  ROM read address.
REQ-013 O_mult_clr  out  1  one-cycle clear of the serial multiplier accumulators.
REQ-014 O_mult_ena  out  1  multiplier enable, aligned to ROM data valid.
REQ-015 O_capture  out  1  one-cycle strobe that latches the accumulated results.
REQ-016 O_busy  out  1  high in every state except IDLE.
REQ-017 O_done  out  1  one-cycle frame-complete pulse.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, RUN, DRAIN, CAPTURE and DONE; all outputs SHALL be driven directly from flops.
REQ-019 IDLE SHALL move to CLEAR on the edge where I_start=1 and I_abort=0.
REQ-020 CLEAR SHALL last exactly 1 cycle with O_mult_clr=1, O_rom_addr=0 and the sample counter at 0, then move to RUN.
REQ-021 RUN SHALL last exactly FRAME_LEN cycles with O_rom_ena=1.
REQ-022 In RUN, O_rom_addr SHALL start at 0 and increment by 1 each cycle, wrapping from ROM_DEPTH-1 to 0.
REQ-023 RUN SHALL move to DRAIN after the cycle in which the sample counter equals FRAME_LEN-1.
REQ-024 O_mult_ena SHALL equal O_rom_ena delayed by exactly ROM_LAT cycles through a shift register, giving exactly FRAME_LEN high cycles per frame.
REQ-025 DRAIN SHALL last DRAIN_CYC cycles with O_rom_ena=0, then move to CAPTURE.
REQ-026 CAPTURE SHALL last 1 cycle with O_capture=1, then move to DONE.
REQ-027 DONE SHALL last 1 cycle with O_done=1.
REQ-028 DONE SHALL then move to CLEAR if I_continuous=1 and I_abort=0, otherwise to IDLE.
REQ-029 Timing, with I_start sampled at edge 0:
  - CLEAR in cycle 1;
  - RUN in cycles 2..FRAME_LEN+1;
  - CAPTURE in cycle FRAME_LEN+DRAIN_CYC+2;
  - DONE in cycle FRAME_LEN+DRAIN_CYC+3.
REQ-030 I_start while O_busy=1 SHALL be ignored, with no queuing and no restart.
REQ-031 I_abort=1 in any non-IDLE state SHALL move the FSM to IDLE at the next edge.
REQ-032 On abort, the delay pipe, counter and address SHALL clear, and O_capture and O_done SHALL NOT pulse for the aborted frame.
REQ-033 I_abort and I_start high in the same IDLE cycle SHALL leave the FSM in IDLE (abort wins).
REQ-034 The sample counter SHALL be $clog2(FRAME_LEN+1) bits wide; the counter and the address SHALL never overflow or carry out of range.

Reset
REQ-035 While I_sys_rst=1, regardless of clock:
  - the FSM SHALL be in IDLE;
  - all outputs SHALL be 0, including O_rom_addr;
  - the counter and the delay pipe SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL abandon the frame immediately with no O_capture or O_done pulse.
REQ-037 After reset deassertion, the block SHALL wait in IDLE for I_start.

Verification (FRAME_LEN=8, ROM_DEPTH=8, ROM_LAT=1, DRAIN_CYC=3 unless stated)
REQ-038 Single frame: I_start pulse at edge 0 -> O_mult_clr in cycle 1, O_rom_addr 0..7 in cycles 2..9, O_mult_ena in cycles 3..10, O_capture in cycle 13, O_done in cycle 14, O_busy low in cycle 15.
REQ-039 Wrap: FRAME_LEN=12, ROM_DEPTH=5 -> address sequence 0,1,2,3,4,0,1,2,3,4,0,1, with exactly 12 O_rom_ena cycles and 12 O_mult_ena cycles.
REQ-040 Abort: I_abort in cycle 5 of RUN -> all outputs 0 from cycle 6, O_busy=0, and no O_capture or O_done.
REQ-041 Start while busy: I_start pulses in cycles 4 and 12 -> timing identical to the single-frame case and only one O_done.
REQ-042 Continuous: I_continuous=1 -> O_mult_clr again in cycle 15 and O_done every 14 cycles; dropping I_continuous before a DONE -> IDLE after that DONE.
REQ-043 Reset mid-DRAIN: I_sys_rst asserted asynchronously -> outputs 0 within the same cycle, and no O_capture.
